// File: rtl/fifo_wr_arb2.sv
// Write-side arbiter and pointer controller for a first-word-fall-through FIFO.
// Define FIFO_ARB_FIXED_PRI_EN for fixed priority (req0 wins); default is round-robin.
module fifo_wr_arb2 #(
    parameter int unsigned DATASIZE = 8,
    parameter int unsigned ADDRSIZE = 4
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                req0,
    input  logic                req1,
    input  logic [DATASIZE-1:0] wdata0,
    input  logic [DATASIZE-1:0] wdata1,
    output logic                gnt0,
    output logic                gnt1,
    input  logic                rinc,
    output logic                rempty,
    output logic                wfull,
    output logic [ADDRSIZE:0]   count,
    output logic [DATASIZE-1:0] mem_wdata,
    output logic [ADDRSIZE-1:0] mem_waddr,
    output logic [ADDRSIZE-1:0] mem_raddr,
    output logic                mem_wclken
);

    localparam logic [ADDRSIZE:0] FULL_XOR = {1'b1, {ADDRSIZE{1'b0}}};
    localparam logic [ADDRSIZE:0] ONE      = {{ADDRSIZE{1'b0}}, 1'b1};

    logic [ADDRSIZE:0] wptr_q, wptr_d;
    logic [ADDRSIZE:0] rptr_q, rptr_d;
    logic [ADDRSIZE:0] count_q, count_d;
    logic              rempty_q, rempty_d;
    logic              wfull_q, wfull_d;
    logic              push, pop;

`ifdef FIFO_ARB_FIXED_PRI_EN
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!wrst && !wfull_q) begin
            gnt0 = req0;
            gnt1 = req1 & ~req0;
        end
    end
`else
    // last_q = 1 means requester 1 was granted most recently, so requester 0 wins a tie
    logic last_q, last_d;

    always_comb begin
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        if (!wrst && !wfull_q) begin
            gnt0 = req0 & (~req1 | last_q);
            gnt1 = req1 & (~req0 | ~last_q);
        end
        last_d = last_q;
        if (gnt0)
            last_d = 1'b0;
        else if (gnt1)
            last_d = 1'b1;
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst)
            last_q <= 1'b1;
        else
            last_q <= last_d;
    end
`endif

    assign push = gnt0 | gnt1;
    assign pop  = rinc & ~rempty_q;

    // Status flags are derived from next-state pointers so they track the edge that moves them
    always_comb begin
        wptr_d   = push ? wptr_q + ONE : wptr_q;
        rptr_d   = pop  ? rptr_q + ONE : rptr_q;
        count_d  = wptr_d - rptr_d;
        rempty_d = (wptr_d == rptr_d);
        wfull_d  = ((wptr_d ^ rptr_d) == FULL_XOR);
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            rempty_q <= 1'b1;
            wfull_q  <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            rempty_q <= rempty_d;
            wfull_q  <= wfull_d;
        end
    end

    assign mem_wclken = push;
    assign mem_wdata  = gnt1 ? wdata1 : wdata0;
    assign mem_waddr  = wptr_q[ADDRSIZE-1:0];
    assign mem_raddr  = rptr_q[ADDRSIZE-1:0];
    assign rempty     = rempty_q;
    assign wfull      = wfull_q;
    assign count      = count_q;

endmodule

// File: tb/tb_fifo_wr_arb2.sv
// Directed bench for fifo_wr_arb2 with a behavioural FIFO memory and a queue scoreboard.
module tb_fifo_wr_arb2;

    logic       wclk = 1'b0;
    logic       wrst;
    logic       req0, req1, rinc;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rempty, wfull, mem_wclken;
    logic [4:0] count;
    logic [7:0] mem_wdata;
    logic [3:0] mem_waddr, mem_raddr;

    logic [7:0] mem [16];
    logic [7:0] rdata;

    int n_vec = 0;
    int n_err = 0;
    int m_wptr = 0;
    int m_rptr = 0;
    logic [7:0] q [$];

    fifo_wr_arb2 #(.DATASIZE(8), .ADDRSIZE(4)) dut (
        .wclk(wclk), .wrst(wrst),
        .req0(req0), .req1(req1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rinc(rinc),
        .rempty(rempty), .wfull(wfull), .count(count),
        .mem_wdata(mem_wdata), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
        .mem_wclken(mem_wclken)
    );

    always #5 wclk = ~wclk;

    always @(posedge wclk)
        if (mem_wclken) mem[mem_waddr] <= mem_wdata;
    assign rdata = mem[mem_raddr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: apply inputs, check combinational outputs, clock, check registered state
    task automatic step(input logic r0, input logic [7:0] d0, input logic r1,
                        input logic [7:0] d1, input logic ri, input logic [1:0] eg);
        logic did_pop;
        req0 = r0; wdata0 = d0; req1 = r1; wdata1 = d1; rinc = ri;
        #3;
        check("gnt", {30'd0, gnt1, gnt0}, {30'd0, eg});
        check("wclken", {31'd0, mem_wclken}, {31'd0, |eg});
        if (|eg) begin
            check("waddr", {28'd0, mem_waddr}, m_wptr % 16);
            check("wdata", {24'd0, mem_wdata}, {24'd0, (eg[1] ? d1 : d0)});
        end
        did_pop = ri && (q.size() > 0);
        if (did_pop)
            check("rdata", {24'd0, rdata}, {24'd0, q[0]});
        @(posedge wclk);
        #1;
        if (did_pop) begin
            void'(q.pop_front());
            m_rptr = (m_rptr + 1) % 32;
        end
        if (|eg) begin
            q.push_back(eg[1] ? d1 : d0);
            m_wptr = (m_wptr + 1) % 32;
        end
        check("count", {27'd0, count}, q.size());
        check("rempty", {31'd0, rempty}, {31'd0, q.size() == 0});
        check("wfull", {31'd0, wfull}, {31'd0, q.size() == 16});
        check("raddr", {28'd0, mem_raddr}, m_rptr % 16);
        $display("step t=%0t req=%b%b rinc=%b gnt=%b%b count=%0d", $time, r1, r0, ri, gnt1, gnt0, count);
    endtask

    task automatic reset_model();
        q.delete();
        m_wptr = 0;
        m_rptr = 0;
    endtask

    initial begin
        wrst = 1'b1; req0 = 1'b0; req1 = 1'b0; rinc = 1'b0; wdata0 = 8'h00; wdata1 = 8'h00;
        repeat (2) @(posedge wclk);
        #1;
        check("rst_count", {27'd0, count}, 0);
        check("rst_rempty", {31'd0, rempty}, 1);
        check("rst_wfull", {31'd0, wfull}, 0);
        check("rst_gnt", {30'd0, gnt1, gnt0}, 0);
        check("rst_wclken", {31'd0, mem_wclken}, 0);
        check("rst_addr", {24'd0, mem_waddr, mem_raddr}, 0);
        wrst = 1'b0;
        @(posedge wclk); #1;

        // single write of 0xA5, then pop it
        step(1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 2'b01);
        check("first_rdata", {24'd0, rdata}, 32'hA5);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'b00);

        // tie arbitration from reset state
        wrst = 1'b1; #1; wrst = 1'b0; reset_model();
        @(posedge wclk); #1;
        for (int i = 0; i < 4; i++) begin
`ifdef FIFO_ARB_FIXED_PRI_EN
            step(1'b1, 8'(8'h10 + i), 1'b1, 8'(8'h20 + i), 1'b0, 2'b01);
`else
            step(1'b1, 8'(8'h10 + i), 1'b1, 8'(8'h20 + i), 1'b0, (i % 2 == 0) ? 2'b01 : 2'b10);
`endif
        end
        check("rr_count4", {27'd0, count}, 4);
        for (int i = 0; i < 4; i++)
            step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'b00);

        // pop while empty is ignored
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'b00);
        check("empty_pop_raddr", {28'd0, mem_raddr}, 4);

        // fill to full, then pop with a blocked write
        for (int i = 0; i < 16; i++)
            step(1'b0, 8'h00, 1'b1, 8'(8'h40 + i), 1'b0, 2'b10);
        check("full_count", {27'd0, count}, 16);
        step(1'b0, 8'h00, 1'b1, 8'h99, 1'b1, 2'b00);
        step(1'b0, 8'h00, 1'b1, 8'h99, 1'b0, 2'b10);
        for (int i = 0; i < 13; i++)
            step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'b00);

        // steady push/pop across pointer wraps
        for (int i = 0; i < 40; i++)
            step(1'b1, 8'(8'h60 + i), 1'b0, 8'h00, 1'b1, 2'b01);
        check("steady_count", {27'd0, count}, 3);

        // drain, then push into empty with a same-cycle ignored pop
        for (int i = 0; i < 3; i++)
            step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'b00);
        step(1'b1, 8'hC3, 1'b0, 8'h00, 1'b1, 2'b01);
        for (int i = 0; i < 6; i++)
            step(1'b0, 8'h00, 1'b1, 8'(8'hD0 + i), 1'b0, 2'b10);
        check("pre_rst_count", {27'd0, count}, 7);

        // asynchronous reset mid-cycle with both requesting
        req0 = 1'b1; req1 = 1'b1; rinc = 1'b0;
        #2; wrst = 1'b1; #1;
        check("arst_count", {27'd0, count}, 0);
        check("arst_rempty", {31'd0, rempty}, 1);
        check("arst_wfull", {31'd0, wfull}, 0);
        check("arst_gnt", {30'd0, gnt1, gnt0}, 0);
        @(posedge wclk); #1;
        check("arst_hold_gnt", {30'd0, gnt1, gnt0}, 0);
        wrst = 1'b0; reset_model();
        for (int i = 0; i < 4; i++) begin
`ifdef FIFO_ARB_FIXED_PRI_EN
            step(1'b1, 8'(8'h80 + i), 1'b1, 8'(8'h90 + i), 1'b0, 2'b01);
`else
            step(1'b1, 8'(8'h80 + i), 1'b1, 8'(8'h90 + i), 1'b0, (i % 2 == 0) ? 2'b01 : 2'b10);
`endif
        end
        for (int i = 0; i < 4; i++)
            step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
